instr_decode_stage: RTL and testbench

//  Single-entry RV32I decode pipeline stage, directly upstream of the register bank.
//  - Accepts fetched instructions over a valid/ready handshake.
//  - Drives rs1_sel/rs2_sel combinationally from its held entry, so rs1_data/rs2_data are valid whenever out_valid=1.
//  - Presents decoded fields (rd_sel, reg_w, imm, class, funct) to execute.
//  - Stalls while the register bank is not ready (reset clear sweep).

---
 rtl/instr_decode_stage.sv | 166 ++++++++++++++++
 tb/tb_instr_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// RV32I single-entry decode stage feeding the register bank; optional illegal detect via DECODE_ILLEGAL_EN.
// Latency 1 cycle in->out_valid; in_ready = RUN && (!held || out_ready), entry held while out_ready=0 or bank not ready.
// Backpressure: stalls (in_ready=0, out_valid=0) while rb_ready=0; held entry survives and is re-presented.
module instr_decode_stage #(
  parameter int BANK_WIDTH     = 5,
  parameter int REGISTER_WIDTH = 32,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               instr,
  input  logic [ADDR_WIDTH-1:0]     pc,
  input  logic                      flush,
  input  logic                      rb_ready,
  output logic [BANK_WIDTH-1:0]     rs1_sel,
  output logic [BANK_WIDTH-1:0]     rs2_sel,
  output logic [BANK_WIDTH-1:0]     rd_sel,
  output logic                      reg_w,
  output logic [REGISTER_WIDTH-1:0] imm,
  output logic [3:0]                iclass,
  output logic [2:0]                funct3,
  output logic                      funct7_b5,
  output logic [ADDR_WIDTH-1:0]     pc_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      illegal
);

  localparam logic [3:0] C_NOP      = 4'd0;
  localparam logic [3:0] C_LUI      = 4'd1;
  localparam logic [3:0] C_AUIPC    = 4'd2;
  localparam logic [3:0] C_JAL      = 4'd3;
  localparam logic [3:0] C_JALR     = 4'd4;
  localparam logic [3:0] C_BRANCH   = 4'd5;
  localparam logic [3:0] C_LOAD     = 4'd6;
  localparam logic [3:0] C_STORE    = 4'd7;
  localparam logic [3:0] C_OP_IMM   = 4'd8;
  localparam logic [3:0] C_OP       = 4'd9;
  localparam logic [3:0] C_MISC_MEM = 4'd10;
  localparam logic [3:0] C_SYSTEM   = 4'd11;

  typedef enum logic {
    WAIT_RB = 1'b0,
    RUN     = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_held_valid;
  logic [31:0]             r_instr;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic                    w_accept;
  logic                    w_consume;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      WAIT_RB: begin
        if (rb_ready) w_state_nxt = RUN;
      end
      RUN: begin
        // Consuming and refilling in the same cycle avoids a bubble.
        in_ready  = !r_held_valid || out_ready;
        out_valid = r_held_valid;
        if (!rb_ready) w_state_nxt = WAIT_RB;
      end
      default: w_state_nxt = WAIT_RB;
    endcase
  end

  assign w_accept  = in_valid && in_ready && !flush;
  assign w_consume = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_RB;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held_valid <= 1'b0;
      r_instr      <= '0;
      r_pc         <= '0;
    end else begin
      if (flush)          r_held_valid <= 1'b0;
      else if (w_accept)  r_held_valid <= 1'b1;
      else if (w_consume) r_held_valid <= 1'b0;
      if (w_accept) begin
        r_instr <= instr;
        r_pc    <= pc;
      end
    end
  end

  logic [6:0]  w_opc;
  logic [4:0]  w_rd_f, w_rs1_f, w_rs2_f;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm32;
  logic [3:0]  w_class;
  logic        w_wr_cls;
  logic        w_block;

  assign w_opc   = r_instr[6:0];
  assign w_rd_f  = r_instr[11:7];
  assign w_rs1_f = r_instr[19:15];
  assign w_rs2_f = r_instr[24:20];

  assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_imm_u = {r_instr[31:12], 12'h000};
  assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};

  always_comb begin
    w_class  = C_NOP;
    w_imm32  = '0;
    w_wr_cls = 1'b0;
    if (w_opc[1:0] == 2'b11) begin
      case (w_opc[6:2])
        5'b01101: begin w_class = C_LUI;      w_imm32 = w_imm_u; w_wr_cls = 1'b1; end
        5'b00101: begin w_class = C_AUIPC;    w_imm32 = w_imm_u; w_wr_cls = 1'b1; end
        5'b11011: begin w_class = C_JAL;      w_imm32 = w_imm_j; w_wr_cls = 1'b1; end
        5'b11001: begin w_class = C_JALR;     w_imm32 = w_imm_i; w_wr_cls = 1'b1; end
        5'b11000: begin w_class = C_BRANCH;   w_imm32 = w_imm_b; end
        5'b00000: begin w_class = C_LOAD;     w_imm32 = w_imm_i; w_wr_cls = 1'b1; end
        5'b01000: begin w_class = C_STORE;    w_imm32 = w_imm_s; end
        5'b00100: begin w_class = C_OP_IMM;   w_imm32 = w_imm_i; w_wr_cls = 1'b1; end
        5'b01100: begin w_class = C_OP;       w_wr_cls = 1'b1; end
        5'b00011: begin w_class = C_MISC_MEM; end
        5'b11100: begin w_class = C_SYSTEM;   end
        default:  begin w_class = C_NOP;      end
      endcase
    end
  end

`ifdef DECODE_ILLEGAL_EN
  logic w_use_rs1, w_use_rs2, w_bad_reg;
  assign w_use_rs1 = (w_class == C_JALR) || (w_class == C_BRANCH) || (w_class == C_LOAD) ||
                     (w_class == C_STORE) || (w_class == C_OP_IMM) || (w_class == C_OP);
  assign w_use_rs2 = (w_class == C_BRANCH) || (w_class == C_STORE) || (w_class == C_OP);
  // Only fields the class actually reads as registers can name an out-of-range register.
  assign w_bad_reg = (w_wr_cls  && ((w_rd_f  >> BANK_WIDTH) != 5'd0)) ||
                     (w_use_rs1 && ((w_rs1_f >> BANK_WIDTH) != 5'd0)) ||
                     (w_use_rs2 && ((w_rs2_f >> BANK_WIDTH) != 5'd0));
  assign w_block   = w_bad_reg;
  assign illegal   = out_valid && ((w_class == C_NOP) || w_bad_reg);
`else
  assign w_block   = 1'b0;
  assign illegal   = 1'b0;
`endif

  assign rs1_sel   = BANK_WIDTH'(w_rs1_f);
  assign rs2_sel   = BANK_WIDTH'(w_rs2_f);
  assign rd_sel    = BANK_WIDTH'(w_rd_f);
  assign iclass    = w_class;
  assign imm       = REGISTER_WIDTH'($signed(w_imm32));
  assign funct3    = r_instr[14:12];
  assign funct7_b5 = r_instr[30];
  assign pc_out    = r_pc;
  assign reg_w     = out_valid && w_wr_cls && (rd_sel != '0) && !w_block;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboarded bench for instr_decode_stage; expectations come from a reference decode model.
module tb_instr_decode_stage;

  logic        clk, rst, in_valid, in_ready, flush, rb_ready;
  logic [31:0] instr, pc, imm, pc_out;
  logic [4:0]  rs1_sel, rs2_sel, rd_sel;
  logic        reg_w, funct7_b5, out_valid, out_ready, illegal;
  logic [3:0]  iclass;
  logic [2:0]  funct3;

  instr_decode_stage #(.BANK_WIDTH(5), .REGISTER_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .flush(flush), .rb_ready(rb_ready), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel),
    .reg_w(reg_w), .imm(imm), .iclass(iclass), .funct3(funct3), .funct7_b5(funct7_b5),
    .pc_out(pc_out), .out_valid(out_valid), .out_ready(out_ready), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic        rw;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
    exp_t e;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.pc = p; e.f3 = ins[14:12]; e.f7 = ins[30];
    e.imm = 32'h0; e.cls = 4'd0;
    case (ins[6:0])
      7'h37: begin e.cls = 4'd1;  e.imm = {ins[31:12], 12'h000}; end
      7'h17: begin e.cls = 4'd2;  e.imm = {ins[31:12], 12'h000}; end
      7'h6F: begin e.cls = 4'd3;  e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h67: begin e.cls = 4'd4;  e.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'h63: begin e.cls = 4'd5;  e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'h03: begin e.cls = 4'd6;  e.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'h23: begin e.cls = 4'd7;  e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'h13: begin e.cls = 4'd8;  e.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'h33: e.cls = 4'd9;
      7'h0F: e.cls = 4'd10;
      7'h73: e.cls = 4'd11;
      default: e.cls = 4'd0;
    endcase
    e.rw = (e.cls inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9}) && (e.rd != 5'd0);
`ifdef DECODE_ILLEGAL_EN
    e.ill = (e.cls == 4'd0);
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  // Drives one cycle of stimulus and keeps the scoreboard in step with the handshake.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic fl, input logic ordy);
    in_valid = v; instr = ins; pc = p; flush = fl; out_ready = ordy;
    #1;
    if (fl) q.delete();
    else begin
      if (out_valid && ordy && q.size() > 0) void'(q.pop_front());
      if (v && in_ready) q.push_back(model(ins, p));
    end
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1; in_valid = 1'b0; instr = 32'h0; pc = 32'h0;
    flush = 1'b0; rb_ready = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out_valid, in_ready, reg_w, illegal} !== 4'b0 || iclass !== 4'd0 || imm !== 32'h0 ||
        pc_out !== 32'h0 || rd_sel !== 5'd0)
      begin n_fail++; $display("FAIL reset_outputs: ov=%b ir=%b rw=%b cls=%0d imm=%h pc=%h want all zero",
                               out_valid, in_ready, reg_w, iclass, imm, pc_out); end
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL wait_rb_hold: %0d cycles with handshake active, want 0", bad); end
    rb_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rb_same_cycle: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL rb_next_cycle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_decode;
    logic [31:0] tbl [8];
    exp_t e;
    tbl[0] = 32'h00500093; tbl[1] = 32'h0020A423; tbl[2] = 32'h00100013; tbl[3] = 32'h123450B7;
    tbl[4] = 32'h008000EF; tbl[5] = 32'h00001117; tbl[6] = 32'hFFC12183; tbl[7] = 32'h402081B3;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i], 32'h100 + 32'(i * 4), 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || q.size() != 1) begin
        n_fail++; $display("FAIL decode_valid[%0d]: out_valid=%b queued=%0d want 1 1", i, out_valid, q.size());
      end else begin
        e = q[0];
        n_tests++;
        if ({iclass, rd_sel, rs1_sel, rs2_sel, reg_w, funct3, funct7_b5} !==
            {e.cls, e.rd, e.rs1, e.rs2, e.rw, e.f3, e.f7})
          begin n_fail++; $display("FAIL decode_ctrl[%0d]: cls=%0d rd=%0d rs1=%0d rs2=%0d rw=%b want %0d %0d %0d %0d %b",
                                   i, iclass, rd_sel, rs1_sel, rs2_sel, reg_w, e.cls, e.rd, e.rs1, e.rs2, e.rw); end
        n_tests++;
        if (imm !== e.imm || pc_out !== e.pc || illegal !== e.ill)
          begin n_fail++; $display("FAIL decode_data[%0d]: imm=%h pc=%h ill=%b want %h %h %b",
                                   i, imm, pc_out, illegal, e.imm, e.pc, e.ill); end
      end
      if (i == 0) begin
        n_tests++;
        if (iclass !== 4'd8 || rd_sel !== 5'd1 || rs1_sel !== 5'd0 || imm !== 32'd5 || reg_w !== 1'b1 || pc_out !== 32'h100)
          begin n_fail++; $display("FAIL addi_fields: cls=%0d rd=%0d rs1=%0d imm=%h rw=%b pc=%h want 8 1 0 5 1 100",
                                   iclass, rd_sel, rs1_sel, imm, reg_w, pc_out); end
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || reg_w !== 1'b0)
        begin n_fail++; $display("FAIL decode_clear[%0d]: out_valid=%b reg_w=%b want 0 0", i, out_valid, reg_w); end
    end
  endtask

  task automatic test_stall_beq;
    drive(1'b1, 32'hFE208EE3, 32'h200, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h00700193, 32'h204, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || imm !== 32'hFFFFFFFC || iclass !== 4'd5 || pc_out !== 32'h200 || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL stall_hold: ov=%b imm=%h cls=%0d pc=%h ir=%b want 1 fffffffc 5 200 0",
                                 out_valid, imm, iclass, pc_out, in_ready); end
    end
    drive(1'b1, 32'h00700193, 32'h204, 1'b0, 1'b1);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL passthrough_rdy: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || iclass !== 4'd8 || rd_sel !== 5'd3 || imm !== 32'd7 || pc_out !== 32'h204)
      begin n_fail++; $display("FAIL passthrough_next: ov=%b cls=%0d rd=%0d imm=%h pc=%h want 1 8 3 7 204",
                               out_valid, iclass, rd_sel, imm, pc_out); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    localparam int N = 10;
    exp_t e;
    drive(1'b1, {12'd1, 5'd0, 3'b000, 5'd1, 7'h13}, 32'h300, 1'b0, 1'b1);
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      n_tests++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL b2b[%0d]: scoreboard empty, want one entry", k);
      end else begin
        e = q[0];
        if (out_valid !== 1'b1 || pc_out !== 32'h300 + 32'((k - 1) * 4) || imm !== e.imm || rd_sel !== e.rd)
          begin n_fail++; $display("FAIL b2b[%0d]: ov=%b pc=%h imm=%h rd=%0d want 1 %h %h %0d",
                                   k, out_valid, pc_out, imm, rd_sel, 32'h300 + 32'((k - 1) * 4), e.imm, e.rd); end
      end
      if (k < N) drive(1'b1, {12'(k + 1), 5'd0, 3'b000, 5'(k + 1), 7'h13}, 32'h300 + 32'(k * 4), 1'b0, 1'b1);
      else       drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || q.size() != 0)
      begin n_fail++; $display("FAIL b2b_drain: ov=%b queued=%0d want 0 0", out_valid, q.size()); end
  endtask

  task automatic test_flush;
    int bad;
    drive(1'b1, 32'h00500293, 32'h400, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || rd_sel !== 5'd5)
      begin n_fail++; $display("FAIL flush_pre: ov=%b rd=%0d want 1 5", out_valid, rd_sel); end
    drive(1'b1, 32'h00600313, 32'h404, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_clear: ov=%b ir=%b want 0 1", out_valid, in_ready); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0 || q.size() != 0)
      begin n_fail++; $display("FAIL flush_drop: %0d cycles valid, queued=%0d want 0 0", bad, q.size()); end
  endtask

  task automatic test_rb_drop;
    drive(1'b1, 32'h000AB3B7, 32'h500, 1'b0, 1'b0);
    @(negedge clk);
    rb_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || reg_w !== 1'b0)
      begin n_fail++; $display("FAIL rb_drop_stall: ov=%b ir=%b rw=%b want 0 0 0", out_valid, in_ready, reg_w); end
    rb_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || iclass !== 4'd1 || imm !== 32'h000AB000 || pc_out !== 32'h500 || rd_sel !== 5'd7 || reg_w !== 1'b1)
      begin n_fail++; $display("FAIL rb_drop_retain: ov=%b cls=%0d imm=%h pc=%h rd=%0d rw=%b want 1 1 000ab000 500 7 1",
                               out_valid, iclass, imm, pc_out, rd_sel, reg_w); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_illegal;
    logic [31:0] tbl [2];
    exp_t e;
    tbl[0] = 32'hFFFFFFFF; tbl[1] = 32'h00500090;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, tbl[i], 32'h600, 1'b0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (q.size() != 1) begin
        n_fail++; $display("FAIL illegal_accept[%0d]: queued=%0d want 1", i, q.size());
      end else begin
        e = q[0];
        if (out_valid !== 1'b1 || illegal !== e.ill || iclass !== 4'd0 || reg_w !== 1'b0 || imm !== 32'h0)
          begin n_fail++; $display("FAIL illegal[%0d]: ov=%b ill=%b cls=%0d rw=%b imm=%h want 1 %b 0 0 0",
                                   i, out_valid, illegal, iclass, reg_w, imm, e.ill); end
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic test_midreset;
    drive(1'b1, 32'h00500093, 32'h700, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || pc_out !== 32'h0 || iclass !== 4'd0 || reg_w !== 1'b0)
      begin n_fail++; $display("FAIL midreset: ov=%b pc=%h cls=%0d rw=%b want 0 0 0 0", out_valid, pc_out, iclass, reg_w); end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL midreset_recover: ir=%b ov=%b want 1 0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_stall_beq();
    test_back_to_back();
    test_flush();
    test_rb_drop();
    test_illegal();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
